// File: rtl/kmp_matcher.sv
// kmp_matcher: streaming Knuth-Morris-Pratt substring matcher.
// The pattern and its failure function arrive precomputed. The text arrives
// as a byte stream through a one-byte hold register. Each SCAN cycle does one
// KMP step on the held byte: advance on equal, take one failure-function
// fallback on mismatch, or drop the byte when nothing is matched yet.
//
// Ports
//   clk           : clock, rising edge
//   reset         : synchronous, active-high
//   ff_valid      : pattern/failure table valid, held high for the whole job
//   pattern       : character i at [i*BYTE +: BYTE]
//   last_pat_idx  : pattern length - 1
//   fail_func     : entry i at [i*MAX_PAT_ADD +: MAX_PAT_ADD], border length of pattern[0..i]
//   s_valid/s_data/s_last : text byte stream with last-byte flag
//   s_ready       : byte accepted when s_valid && s_ready (combinational)
//   o_match_valid : one-cycle pulse per full match
//   o_match_pos   : start position of the most recent match
//   o_match_cnt   : saturating match count for the current job
//   o_done        : high while in DONE
module kmp_matcher #(
    parameter int unsigned BYTE        = 8,
    parameter int unsigned MAX_PATTERN = 8,
    parameter int unsigned MAX_PAT_ADD = 3,
    parameter int unsigned MAX_STR_ADD = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ff_valid,
    input  logic [MAX_PATTERN*BYTE-1:0]    pattern,
    input  logic [MAX_PAT_ADD-1:0]         last_pat_idx,
    input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] fail_func,
    input  logic                           s_valid,
    input  logic [BYTE-1:0]                s_data,
    input  logic                           s_last,
    output logic                           s_ready,
    output logic                           o_match_valid,
    output logic [MAX_STR_ADD-1:0]         o_match_pos,
    output logic [MAX_STR_ADD:0]           o_match_cnt,
    output logic                           o_done
);

    localparam int unsigned CNT_W = MAX_STR_ADD + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [MAX_PAT_ADD-1:0] j_q, j_d;
    logic [MAX_STR_ADD-1:0] pos_q, pos_d;
    logic [BYTE-1:0]        hold_byte_q, hold_byte_d;
    logic                   hold_last_q, hold_last_d;
    logic                   hold_full_q, hold_full_d;
    logic                   mvalid_q, mvalid_d;
    logic [MAX_STR_ADD-1:0] mpos_q, mpos_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;

    // Unpacked views of the flat pattern and failure-function buses
    logic [BYTE-1:0]        pat_arr [MAX_PATTERN];
    logic [MAX_PAT_ADD-1:0] ff_arr  [MAX_PATTERN];

    for (genvar g = 0; g < MAX_PATTERN; g++) begin : g_unpack
        assign pat_arr[g] = pattern[g*BYTE +: BYTE];
        assign ff_arr[g]  = fail_func[g*MAX_PAT_ADD +: MAX_PAT_ADD];
    end

    // KMP step qualifiers for the held byte
    logic                   step_en;
    logic                   chr_eq;
    logic                   at_last;
    logic                   consume;
    logic [MAX_PAT_ADD-1:0] fb_idx;

    always_comb begin : step_comb
        step_en = (state_q == SCAN) && ff_valid && hold_full_q;
        chr_eq  = (pat_arr[j_q] == hold_byte_q);
        at_last = (j_q == last_pat_idx);
        fb_idx  = j_q - MAX_PAT_ADD'(1);
        // A mismatch with j > 0 keeps the byte and only falls back
        consume = step_en && (chr_eq || (j_q == '0));
    end

    // State register
    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin : next_state_comb
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ff_valid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!ff_valid) begin
                    state_d = IDLE;
                end else if (consume && hold_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!ff_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin : output_comb
        j_d         = j_q;
        pos_d       = pos_q;
        hold_byte_d = hold_byte_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        mvalid_d    = 1'b0;
        mpos_d      = mpos_q;
        cnt_d       = cnt_q;
        done_d      = (state_d == DONE);
        s_ready     = 1'b0;

        if ((state_q == SCAN) && ff_valid) begin
            // Once the last byte is held, accept nothing more for this job
            s_ready = !hold_full_q || (consume && !hold_last_q);

            if (step_en) begin
                if (chr_eq) begin
                    if (at_last) begin
                        mvalid_d = 1'b1;
                        mpos_d   = pos_q - MAX_STR_ADD'(last_pat_idx);
                        j_d      = ff_arr[last_pat_idx];
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        j_d = j_q + MAX_PAT_ADD'(1);
                    end
                end else if (j_q != '0) begin
                    j_d = ff_arr[fb_idx];
                end
            end

            if (consume) begin
                pos_d       = pos_q + MAX_STR_ADD'(1);
                hold_full_d = 1'b0;
                hold_last_d = 1'b0;
            end

            if (s_valid && s_ready) begin
                hold_byte_d = s_data;
                hold_last_d = s_last;
                hold_full_d = 1'b1;
            end
        end

        // Entering or sitting in IDLE clears the job context; SCAN then starts clean
        if (state_d == IDLE) begin
            j_d         = '0;
            pos_d       = '0;
            hold_byte_d = '0;
            hold_last_d = 1'b0;
            hold_full_d = 1'b0;
            mvalid_d    = 1'b0;
            mpos_d      = '0;
            cnt_d       = '0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin : data_reg
        if (reset) begin
            j_q         <= '0;
            pos_q       <= '0;
            hold_byte_q <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            mvalid_q    <= 1'b0;
            mpos_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            j_q         <= j_d;
            pos_q       <= pos_d;
            hold_byte_q <= hold_byte_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            mvalid_q    <= mvalid_d;
            mpos_q      <= mpos_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    assign o_match_valid = mvalid_q;
    assign o_match_pos   = mpos_q;
    assign o_match_cnt   = cnt_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_kmp_matcher.sv
// tb_kmp_matcher: directed self-checking bench for kmp_matcher.
// Expected match positions, counts and stall cycles are hand-derived per job.
module tb_kmp_matcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        ff_valid;
    logic [63:0] pattern;
    logic [2:0]  last_pat_idx;
    logic [23:0] fail_func;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        o_match_valid;
    logic [4:0]  o_match_pos;
    logic [5:0]  o_match_cnt;
    logic        o_done;

    int n_cmp = 0;
    int n_err = 0;
    int stalls = 0;
    int mq[$];

    kmp_matcher dut (
        .clk           (clk),
        .reset         (reset),
        .ff_valid      (ff_valid),
        .pattern       (pattern),
        .last_pat_idx  (last_pat_idx),
        .fail_func     (fail_func),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .o_match_valid (o_match_valid),
        .o_match_pos   (o_match_pos),
        .o_match_cnt   (o_match_cnt),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    // Record match pulses and cycles where an offered byte is refused
    always @(negedge clk) begin
        if (o_match_valid) mq.push_back(int'(o_match_pos));
        if (s_valid && !s_ready) stalls = stalls + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_job(input string p, input string fs);
        pattern      = '0;
        fail_func    = '0;
        for (int i = 0; i < p.len(); i++) begin
            pattern[i*8 +: 8]   = p[i];
            fail_func[i*3 +: 3] = 3'(fs[i] - 8'd48);
        end
        last_pat_idx = 3'(p.len() - 1);
    endtask

    // Start a job: raise ff_valid and wait one edge so the DUT is in SCAN
    task automatic start_job(input string p, input string fs);
        set_job(p, fs);
        ff_valid = 1'b1;
        @(posedge clk); #1;
        mq.delete();
    endtask

    task automatic send_str(input string tag, input string str, input bit gaps, input bit mark_last);
        int b;
        for (int i = 0; i < str.len(); i++) begin
            if (gaps) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = str[i];
            s_last  = mark_last && (i == str.len() - 1);
            b = 0;
            @(negedge clk);
            while (!s_ready && b < 50) begin
                @(negedge clk);
                b++;
            end
            if (!s_ready) chk_eq({tag, "_accept_timeout"}, 32'(s_ready), 32'd1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_job(input string tag, input string p, input string fs, input string text,
                           input bit gaps, input int n, input int e0, input int e1, input int e2,
                           input int exp_st);
        int ep[3];
        int st0;
        int b;
        int held_cnt;
        ep[0] = e0; ep[1] = e1; ep[2] = e2;
        start_job(p, fs);
        st0 = stalls;
        send_str(tag, text, gaps, 1'b1);
        b = 0;
        while (!o_done && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        chk_eq({tag, "_done"}, 32'(o_done), 32'd1);
        @(negedge clk); #1;
        chk_eq({tag, "_nmatch"}, 32'(mq.size()), 32'(n));
        for (int k = 0; k < n && k < mq.size(); k++)
            chk_eq($sformatf("%s_pos%0d", tag, k), 32'(mq[k]), 32'(ep[k]));
        chk_eq({tag, "_cnt"}, 32'(o_match_cnt), 32'(n));
        chk_eq({tag, "_lastpos"}, 32'(o_match_pos), (n > 0) ? 32'(ep[n-1]) : 32'd0);
        if (exp_st >= 0) chk_eq({tag, "_stalls"}, 32'(stalls - st0), 32'(exp_st));
        held_cnt = n;
        @(posedge clk); #1;
        chk_eq({tag, "_done_hold"}, 32'(o_done), 32'd1);
        chk_eq({tag, "_cnt_hold"}, 32'(o_match_cnt), 32'(held_cnt));
        ff_valid = 1'b0;
        @(posedge clk); #1;
        chk_eq({tag, "_idle_done"}, 32'(o_done), 32'd0);
        chk_eq({tag, "_idle_cnt"}, 32'(o_match_cnt), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk_eq({tag, "_ready"}, 32'(s_ready), 32'd0);
        chk_eq({tag, "_mvalid"}, 32'(o_match_valid), 32'd0);
        chk_eq({tag, "_mpos"}, 32'(o_match_pos), 32'd0);
        chk_eq({tag, "_cnt"}, 32'(o_match_cnt), 32'd0);
        chk_eq({tag, "_done"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        ff_valid     = 1'b0;
        pattern      = '0;
        last_pat_idx = '0;
        fail_func    = '0;
        s_valid      = 1'b0;
        s_data       = '0;
        s_last       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Overlapping matches, continuous stream, no refusals
        run_job("abab", "ABAB", "0012", "ABABABAB", 1'b0, 3, 0, 2, 4, 0);
        // One fallback cycle with the next byte refused
        run_job("aab", "AAB", "010", "AAAB", 1'b0, 1, 1, 0, 0, 1);
        // Single-character pattern with random source gaps
        run_job("a1", "A", "0", "BAAB", 1'b1, 2, 1, 2, 0, -1);
        // No match; two fallbacks, one of them with a byte pending
        run_job("abc", "ABC", "000", "ABABD", 1'b0, 0, 0, 0, 0, 1);

        // Reset mid-SCAN after 3 bytes
        start_job("ABAB", "0012");
        send_str("rst", "ABA", 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_quiet("rst_mid");
        reset    = 1'b0;
        ff_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_nopulse", 32'(mq.size()), 32'd0);
        run_job("after_rst", "AAB", "010", "AAAB", 1'b0, 1, 1, 0, 0, 1);

        // Abort by dropping ff_valid mid-SCAN after 3 bytes
        start_job("ABAB", "0012");
        send_str("abort", "ABA", 1'b0, 1'b0);
        ff_valid = 1'b0;
        @(posedge clk); #1;
        chk_quiet("abort_mid");
        repeat (2) @(posedge clk);
        #1;
        chk_eq("abort_nopulse", 32'(mq.size()), 32'd0);
        run_job("after_abort", "ABAB", "0012", "ABABABAB", 1'b0, 3, 0, 2, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kmp_matcher.md
KMP_MATCHER -- requirements
Module: kmp_matcher

Interface
REQ-001 SHALL have parameter BYTE, 8, character width in bits.
REQ-002 SHALL have parameter MAX_PATTERN, 8, maximum pattern length in characters.
REQ-003 SHALL have parameter MAX_PAT_ADD, 3, pattern index width (clog2 MAX_PATTERN).
REQ-004 SHALL have parameter MAX_STR_ADD, 5, string position width.
REQ-005 SHALL have port clk, input, 1, clock (all logic on rising edge).
REQ-006 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port ff_valid, input, 1, failure-function table and pattern valid; held high for the whole job.
REQ-008 SHALL have port pattern, input, MAX_PATTERN*BYTE, character i at bits [i*BYTE +: BYTE].
REQ-009 SHALL have port last_pat_idx, input, MAX_PAT_ADD, index of the last pattern character (pattern length-1).
REQ-010 SHALL have port fail_func, input, MAX_PAT_ADD*MAX_PATTERN, entry i at [i*MAX_PAT_ADD +: MAX_PAT_ADD] = longest proper border length of pattern[0..i].
REQ-011 SHALL have ports s_valid (in, 1), s_data (in, BYTE) and s_last (in, 1): text byte stream, last byte flag.
REQ-012 SHALL have port s_ready, output, 1, byte accepted when s_valid && s_ready.
REQ-013 SHALL have port o_match_valid, output, 1, one-cycle pulse per full match.
REQ-014 SHALL have port o_match_pos, output, MAX_STR_ADD, start position of reported match.
REQ-015 SHALL have port o_match_cnt, output, MAX_STR_ADD+1, matches found in current job.
REQ-016 SHALL have port o_done, output, 1, job complete, high in DONE.

Function
REQ-017 SHALL implement FSM IDLE, SCAN, DONE: IDLE->SCAN when ff_valid; SCAN->DONE after the step consuming the s_last byte; DONE->IDLE when !ff_valid; SCAN->IDLE when !ff_valid (abort).
REQ-018 SHALL keep a one-byte hold register (hold_byte, hold_last, hold_full), matched-length j, and byte counter pos; all cleared on entry to SCAN.
REQ-019 SHALL drive s_ready = (state==SCAN) && (!hold_full || step consumes hold this cycle); s_ready low in IDLE and DONE.
REQ-020 SHALL perform one KMP step per SCAN cycle while hold_full; comparison uses pattern[j] vs hold_byte.
REQ-021 SHALL, on equal with j==last_pat_idx: consume byte, pulse o_match_valid next cycle, o_match_pos = pos-last_pat_idx (mod 2^MAX_STR_ADD), j <= fail_func[last_pat_idx].
REQ-022 SHALL, on equal with j<last_pat_idx: consume byte, j <= j+1.
REQ-023 SHALL, on mismatch with j>0: not consume, j <= fail_func[j-1] (one fallback per cycle, s_ready low unless hold empty).
REQ-024 SHALL, on mismatch with j==0: consume byte, j unchanged.
REQ-025 SHALL, on consume, increment pos (wrap at 2^MAX_STR_ADD) and refill hold in the same cycle if s_valid && s_ready.
REQ-026 SHALL increment o_match_cnt per match, saturating at all-ones.
REQ-027 SHALL hold o_match_pos and o_match_cnt stable in DONE until return to IDLE; o_match_cnt clears on entry to SCAN.
REQ-028 SHALL treat last_pat_idx=0 as single-character pattern (every equal byte is a match, j stays 0).
REQ-029 SHALL discard hold contents and assert no match pulse after abort to IDLE.

Reset
REQ-030 SHALL on reset: state IDLE, j=0, pos=0, hold_full=0, s_ready=0, o_match_valid=0, o_match_pos=0, o_match_cnt=0, o_done=0; reset mid-SCAN takes effect next edge, no further pulses.

Verification
REQ-031 SHALL cover: pattern "ABAB" (last=3, fail 0,0,1,2), text "ABABABAB" streamed continuously -> matches pos 0,2,4, cnt=3, o_done.
REQ-032 SHALL cover: pattern "AAB" (last=2, fail 0,1,0), text "AAAB" -> one fallback cycle with s_ready low, match pos 1, cnt=1.
REQ-033 SHALL cover: pattern "A" (last=0), text "BAAB" with random s_valid gaps -> matches pos 1,2, cnt=2.
REQ-034 SHALL cover: pattern "ABC", text "ABABD" -> no pulses, cnt=0, o_done after last byte.
REQ-035 SHALL cover: reset asserted (and separately ff_valid dropped) mid-SCAN after 3 bytes -> IDLE next cycle, all outputs at reset values/no pulse; next job counts from 0.
